// File: rtl/text_renderer.sv
// text_renderer: turns timing-generator pixel positions into RGB pixels for an
// 80x30 text screen of 8x16 glyph cells (640x480). A character buffer read port
// and a font ROM, both with one clock of read latency, sit in the loop, which
// gives a fixed three-clock latency from the timing inputs to the outputs.
// Optional feature macro: TEXT_CURSOR_EN (blinking underline cursor).
module text_renderer #(
  parameter int COLS    = 80,
  parameter int ROWS    = 30,
  parameter int BLINK_W = 6
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  input  logic        de_i,
  input  logic        hs_i,
  input  logic        vs_i,
  output logic [11:0] cb_addr_o,
  output logic        cb_ce_o,
  input  logic [7:0]  cb_data_i,
  output logic [11:0] font_addr_o,
  input  logic [7:0]  font_data_i,
  input  logic [23:0] fg_color_i,
  input  logic [23:0] bg_color_i,
  input  logic [6:0]  cursor_col_i,
  input  logic [4:0]  cursor_row_i,
  output logic [23:0] rgb_o,
  output logic        de_o,
  output logic        hs_o,
  output logic        vs_o
);

  // First pixel row below the text area; everything from here down is background.
  localparam logic [9:0] TEXT_H = 10'(ROWS * 16);

  logic [4:0]  row0;
  logic [6:0]  col0;

  logic [9:0]  x1_q, x1_d, y1_q, y1_d;
  logic        de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [9:0]  x2_q, x2_d, y2_q, y2_d;
  logic        de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [23:0] rgb_q, rgb_d;
  logic        de3_q, de3_d, hs3_q, hs3_d, vs3_q, vs3_d;

  logic        glyph_bit;
  logic        pixel;

  // Character-buffer address for the cell under the current pixel; 80 is built from shifts.
  always_comb begin
    row0 = y_i[8:4];
    col0 = x_i[9:3];
    if (COLS == 80) begin
      cb_addr_o = {1'b0, row0, 6'b0} + {3'b0, row0, 4'b0} + {5'b0, col0};
    end else begin
      cb_addr_o = 12'(row0 * COLS) + {5'b0, col0};
    end
  end

  // The read port is enabled whenever the block is out of reset.
  assign cb_ce_o = rst_n_i;

  // Glyph row travels one stage so it meets the character code returned by the buffer.
  assign font_addr_o = {cb_data_i, y1_q[3:0]};

`ifdef TEXT_CURSOR_EN
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               cursor_hit;

  // Frame counter advancing on each vsync rising edge; its MSB is the blink phase.
  always_comb begin
    blink_d = blink_q;
    if (vs_i && !vs1_q) begin
      blink_d = blink_q + {{(BLINK_W-1){1'b0}}, 1'b1};
    end
  end

  // Blink counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end

  // Cursor is an inverted underline on glyph rows 14-15 of the selected cell.
  always_comb begin
    cursor_hit = (x2_q[9:3] == cursor_col_i) && (y2_q[8:4] == cursor_row_i) &&
                 (y2_q[3:1] == 3'b111) && blink_q[BLINK_W-1];
  end
`else
  // The cursor ports and upper x bits of the last stage have no use without the cursor.
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col_i, cursor_row_i, x2_q[9:3]};
`endif

  // Pick the font bit for this pixel (bit7 is leftmost) and apply the cursor if present.
  always_comb begin
    glyph_bit = font_data_i[3'd7 - x2_q[2:0]];
`ifdef TEXT_CURSOR_EN
    pixel = glyph_bit ^ cursor_hit;
`else
    pixel = glyph_bit;
`endif
  end

  // Next-state for the timing/position chains and the output colour.
  always_comb begin
    x1_d  = x_i;
    y1_d  = y_i;
    de1_d = de_i;
    hs1_d = hs_i;
    vs1_d = vs_i;
    x2_d  = x1_q;
    y2_d  = y1_q;
    de2_d = de1_q;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    de3_d = de2_q;
    hs3_d = hs2_q;
    vs3_d = vs2_q;
    rgb_d = 24'h000000;
    if (de2_q) begin
      if (y2_q < TEXT_H) begin
        rgb_d = pixel ? fg_color_i : bg_color_i;
      end else begin
        rgb_d = bg_color_i;
      end
    end
  end

  // Pipeline registers; reset flushes every stage to zero.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      x1_q  <= '0;
      y1_q  <= '0;
      de1_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      x2_q  <= '0;
      y2_q  <= '0;
      de2_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      rgb_q <= '0;
      de3_q <= 1'b0;
      hs3_q <= 1'b0;
      vs3_q <= 1'b0;
    end else begin
      x1_q  <= x1_d;
      y1_q  <= y1_d;
      de1_q <= de1_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      x2_q  <= x2_d;
      y2_q  <= y2_d;
      de2_q <= de2_d;
      hs2_q <= hs2_d;
      vs2_q <= vs2_d;
      rgb_q <= rgb_d;
      de3_q <= de3_d;
      hs3_q <= hs3_d;
      vs3_q <= vs3_d;
    end
  end

  assign rgb_o = rgb_q;
  assign de_o  = de3_q;
  assign hs_o  = hs3_q;
  assign vs_o  = vs3_q;

endmodule

// File: tb/tb_text_renderer.sv
// Testbench for text_renderer: models the character buffer and font ROM as
// one-clock-latency memories and checks directed scenarios. Cursor expectations
// follow the TEXT_CURSOR_EN macro.
module tb_text_renderer;

  logic        clk;
  logic        rst_n_i;
  logic [9:0]  x_i, y_i;
  logic        de_i, hs_i, vs_i;
  logic [11:0] cb_addr_o;
  logic        cb_ce_o;
  logic [7:0]  cb_data_i;
  logic [11:0] font_addr_o;
  logic [7:0]  font_data_i;
  logic [23:0] fg_color_i, bg_color_i;
  logic [6:0]  cursor_col_i;
  logic [4:0]  cursor_row_i;
  logic [23:0] rgb_o;
  logic        de_o, hs_o, vs_o;

  int checks;
  int failures;

  logic [7:0] cb_mem   [0:4095];
  logic [7:0] font_mem [0:4095];

  text_renderer dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .x_i          (x_i),
    .y_i          (y_i),
    .de_i         (de_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .cb_addr_o    (cb_addr_o),
    .cb_ce_o      (cb_ce_o),
    .cb_data_i    (cb_data_i),
    .font_addr_o  (font_addr_o),
    .font_data_i  (font_data_i),
    .fg_color_i   (fg_color_i),
    .bg_color_i   (bg_color_i),
    .cursor_col_i (cursor_col_i),
    .cursor_row_i (cursor_row_i),
    .rgb_o        (rgb_o),
    .de_o         (de_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o)
  );

  // Pixel clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Character buffer read port: one clock latency, gated by the clock enable.
  always @(posedge clk) begin
    if (cb_ce_o) cb_data_i <= cb_mem[cb_addr_o];
  end

  // Font ROM: one clock latency.
  always @(posedge clk) begin
    font_data_i <= font_mem[font_addr_o];
  end

  // Safety net so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one input vector, let one rising edge sample it, return 1 time unit later.
  task automatic tick(input logic [9:0] x, input logic [9:0] y,
                      input logic de, input logic hs, input logic vs);
    x_i  = x;
    y_i  = y;
    de_i = de;
    hs_i = hs;
    vs_i = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cursor_col_i = 7'($urandom_range(0, 79));
      cursor_row_i = 5'($urandom_range(0, 29));
      tick(10'($urandom_range(0, 799)), 10'($urandom_range(0, 524)),
           1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if ({rgb_o, de_o, hs_o, vs_o, cb_ce_o} !== 28'h0) begin
        failures++;
        $display("[TB] FAIL reset_hold: rgb=%h de=%b hs=%b vs=%b ce=%b expected all 0",
                 rgb_o, de_o, hs_o, vs_o, cb_ce_o);
      end
    end
    cursor_col_i = 7'd5;
    cursor_row_i = 5'd2;
    rst_n_i = 1'b1;
    #1;
    checks++;
    if (cb_ce_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ce: got %b expected 1", cb_ce_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick(10'd16, 10'd16, 1'b1, 1'b1, 1'b1);
      if (i < 2) begin
        checks++;
        if ({rgb_o, de_o, hs_o, vs_o} !== 27'h0) begin
          failures++;
          $display("[TB] FAIL reset_release_zero%0d: rgb=%h de=%b expected 0", i, rgb_o, de_o);
        end
      end else begin
        checks++;
        if ({rgb_o, de_o, hs_o, vs_o} !== {24'h112233, 3'b111}) begin
          failures++;
          $display("[TB] FAIL reset_release_live: rgb=%h de=%b hs=%b vs=%b expected 112233 1 1 1",
                   rgb_o, de_o, hs_o, vs_o);
        end
      end
    end
  endtask

  task automatic test_addressing;
    x_i = 10'd639; y_i = 10'd479; #1;
    checks++;
    if (cb_addr_o !== 12'd2399) begin
      failures++;
      $display("[TB] FAIL addr_max: got %0d expected 2399", cb_addr_o);
    end
    x_i = 10'd7; y_i = 10'd15; #1;
    checks++;
    if (cb_addr_o !== 12'd0) begin
      failures++;
      $display("[TB] FAIL addr_cell0: got %0d expected 0", cb_addr_o);
    end
    x_i = 10'd8; y_i = 10'd16; #1;
    checks++;
    if (cb_addr_o !== 12'd81) begin
      failures++;
      $display("[TB] FAIL addr_81: got %0d expected 81", cb_addr_o);
    end
    cb_mem[81] = 8'h41;
    tick(10'd8, 10'd16, 1'b1, 1'b0, 1'b0);
    checks++;
    if (font_addr_o !== 12'h410) begin
      failures++;
      $display("[TB] FAIL font_addr: got %h expected 410", font_addr_o);
    end
  endtask

  // Stream one 8-pixel cell plus two flush pixels and check every pixel of the cell.
  task automatic test_cell_stream(input int col, input int row, input int grow,
                                  input logic [7:0] chr, input logic [7:0] fbyte,
                                  input logic [23:0] fg, input logic [23:0] bg);
    logic [23:0] exp;
    logic [9:0]  xv;
    logic [3:0]  iv;
    cb_mem[row * 80 + col] = chr;
    font_mem[{chr, 4'(grow)}] = fbyte;
    fg_color_i = fg;
    bg_color_i = bg;
    for (int i = 0; i < 10; i++) begin
      xv = 10'(col * 8 + i);
      iv = 4'(i);
      tick(xv, 10'(row * 16 + grow), 1'b1, iv[0], iv[2]);
      if (i >= 2) begin
        iv  = 4'(i - 2);
        exp = fbyte[9 - i] ? fg : bg;
        checks++;
        if ({rgb_o, de_o, hs_o, vs_o} !== {exp, 1'b1, iv[0], iv[2]}) begin
          failures++;
          $display("[TB] FAIL pixel c%0d r%0d p%0d: rgb=%h de=%b hs=%b vs=%b expected %h 1 %b %b",
                   col, row, i - 2, rgb_o, de_o, hs_o, vs_o, exp, iv[0], iv[2]);
        end
      end
    end
  endtask

  task automatic test_pixel_order;
    test_cell_stream(3, 2, 5, 8'h42, 8'h80, 24'hFFFFFF, 24'h000000);
    test_cell_stream(79, 29, 15, 8'h5A, 8'hA5, 24'h123456, 24'hABCDEF);
  endtask

  task automatic test_colour_change;
    fg_color_i = 24'h00FF00;
    bg_color_i = 24'h0000AA;
    for (int i = 0; i < 3; i++) tick(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (rgb_o !== 24'h0000AA) begin
      failures++;
      $display("[TB] FAIL colour_before: got %h expected 0000aa", rgb_o);
    end
    bg_color_i = 24'h00AA00;
    tick(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (rgb_o !== 24'h00AA00) begin
      failures++;
      $display("[TB] FAIL colour_change: got %h expected 00aa00", rgb_o);
    end
  endtask

  task automatic test_blanking;
    fg_color_i = 24'hFFFFFF;
    bg_color_i = 24'h334455;
    for (int i = 0; i < 3; i++) tick(10'd100, 10'd100, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({rgb_o, de_o} !== 25'h0) begin
      failures++;
      $display("[TB] FAIL blanking: rgb=%h de=%b expected 0 0", rgb_o, de_o);
    end
    cb_mem[2412] = 8'h7F;
    font_mem[12'h7F0] = 8'hFF;
    for (int i = 0; i < 3; i++) tick(10'd100, 10'd480, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({rgb_o, de_o} !== {24'h334455, 1'b1}) begin
      failures++;
      $display("[TB] FAIL bottom_area: rgb=%h de=%b expected 334455 1", rgb_o, de_o);
    end
  endtask

  task automatic test_mid_reset;
    logic [23:0] exp;
    cb_mem[197] = 8'h43;
    font_mem[12'h435] = 8'h55;
    fg_color_i = 24'hFFFFFF;
    bg_color_i = 24'h0000FF;
    for (int i = 0; i < 10; i++) begin
      rst_n_i = (i != 4);
      if (i == 4) begin
        #1;
        checks++;
        if (cb_ce_o !== 1'b0) begin
          failures++;
          $display("[TB] FAIL midreset_ce: got %b expected 0", cb_ce_o);
        end
      end
      tick(10'(296 + i), 10'd37, 1'b1, 1'b0, 1'b0);
      if (i == 3 || i >= 7) begin
        exp = (i == 8) ? 24'h0000FF : 24'hFFFFFF;
        checks++;
        if ({rgb_o, de_o} !== {exp, 1'b1}) begin
          failures++;
          $display("[TB] FAIL midreset_live%0d: rgb=%h de=%b expected %h 1", i, rgb_o, de_o, exp);
        end
      end else if (i >= 4) begin
        checks++;
        if ({rgb_o, de_o} !== 25'h0) begin
          failures++;
          $display("[TB] FAIL midreset_zero%0d: rgb=%h de=%b expected 0 0", i, rgb_o, de_o);
        end
      end
    end
    rst_n_i = 1'b1;
  endtask

  task automatic test_cursor;
    logic [23:0] exp_on;
    fg_color_i = 24'hC0C0C0;
    bg_color_i = 24'h202020;
    cursor_col_i = 7'd5;
    cursor_row_i = 5'd2;
`ifdef TEXT_CURSOR_EN
    exp_on = 24'hC0C0C0;
`else
    exp_on = 24'h202020;
`endif
    rst_n_i = 1'b0;
    tick(10'd0, 10'd500, 1'b0, 1'b0, 1'b0);
    tick(10'd0, 10'd500, 1'b0, 1'b0, 1'b0);
    rst_n_i = 1'b1;
    for (int p = 0; p < 31; p++) begin
      tick(10'd0, 10'd500, 1'b0, 1'b0, 1'b1);
      tick(10'd0, 10'd500, 1'b0, 1'b0, 1'b0);
    end
    tick(10'd40, 10'd46, 1'b1, 1'b0, 1'b0);
    tick(10'd0, 10'd500, 1'b0, 1'b0, 1'b0);
    tick(10'd0, 10'd500, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rgb_o !== 24'h202020) begin
      failures++;
      $display("[TB] FAIL cursor_phase_off: got %h expected 202020", rgb_o);
    end
    tick(10'd0, 10'd500, 1'b0, 1'b0, 1'b1);
    tick(10'd0, 10'd500, 1'b0, 1'b0, 1'b0);
    for (int gr = 14; gr < 16; gr++) begin
      for (int i = 0; i < 10; i++) begin
        tick(10'(40 + i), 10'(32 + gr), 1'b1, 1'b0, 1'b0);
        if (i >= 2) begin
          checks++;
          if (rgb_o !== exp_on) begin
            failures++;
            $display("[TB] FAIL cursor_row%0d_x%0d: got %h expected %h", gr, 38 + i, rgb_o, exp_on);
          end
        end
      end
    end
    tick(10'd40, 10'd45, 1'b1, 1'b0, 1'b0);
    tick(10'd48, 10'd47, 1'b1, 1'b0, 1'b0);
    tick(10'd0, 10'd500, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rgb_o !== 24'h202020) begin
      failures++;
      $display("[TB] FAIL cursor_glyphrow13: got %h expected 202020", rgb_o);
    end
    tick(10'd0, 10'd500, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rgb_o !== 24'h202020) begin
      failures++;
      $display("[TB] FAIL cursor_col6: got %h expected 202020", rgb_o);
    end
  endtask

  // Test sequence.
  initial begin
    checks       = 0;
    failures     = 0;
    rst_n_i      = 1'b0;
    x_i          = '0;
    y_i          = '0;
    de_i         = 1'b0;
    hs_i         = 1'b0;
    vs_i         = 1'b0;
    fg_color_i   = 24'hFFFFFF;
    bg_color_i   = 24'h112233;
    cursor_col_i = '0;
    cursor_row_i = '0;
    cb_data_i    = '0;
    font_data_i  = '0;
    for (int a = 0; a < 4096; a++) begin
      cb_mem[a]   = 8'h00;
      font_mem[a] = 8'h00;
    end
    test_reset();
    test_addressing();
    test_pixel_order();
    test_colour_change();
    test_blanking();
    test_mid_reset();
    test_cursor();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
